// File: rtl/apb_cpl_pkg.sv
// Shared constants, address map and FSM state type for the APB weight completer.
// APB_CPL_WAIT_EN (when defined) maps the WAIT register at ADDR_WAIT.
package apb_cpl_pkg;

    localparam int unsigned NUM_WEIGHTS = 8;
    localparam int unsigned WEIGHT_W    = 10;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned BYTE_W      = 8;

    localparam int unsigned ADDR_WLO_BASE = 'h00;
    localparam int unsigned ADDR_CTRL     = 'h10;
    localparam int unsigned ADDR_STATUS   = 'h11;
    localparam int unsigned ADDR_WAIT     = 'h12;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } cpl_state_t;

endpackage

// File: rtl/apb_weight_completer_bank.sv
// Shadow/committed weight storage with a byte write port, bulk commit and PENDING flag.
module weight_shadow_bank
    import apb_cpl_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  wr_en,
    input  logic [IDX_W:0]                        wr_byte,
    input  logic [BYTE_W-1:0]                     wr_data,
    input  logic                                  commit,
    input  logic [IDX_W:0]                        rd_byte,
    output logic [BYTE_W-1:0]                     rd_data,
    output logic                                  pending,
    output logic [NUM_WEIGHTS-1:0][WEIGHT_W-1:0]  committed
);

    logic [NUM_WEIGHTS-1:0][WEIGHT_W-1:0] shadow_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q  <= '0;
            committed <= '0;
            pending   <= 1'b0;
        end else begin
            if (wr_en) begin
                // Odd byte holds the two MSBs of the weight; the rest of that byte is dropped
                if (wr_byte[0])
                    shadow_q[wr_byte[IDX_W:1]][WEIGHT_W-1:BYTE_W] <= wr_data[WEIGHT_W-BYTE_W-1:0];
                else
                    shadow_q[wr_byte[IDX_W:1]][BYTE_W-1:0] <= wr_data;
                pending <= 1'b1;
            end
            if (commit) begin
                committed <= shadow_q;
                pending   <= 1'b0;
            end
        end
    end

    assign rd_data = rd_byte[0]
        ? {{(2*BYTE_W-WEIGHT_W){1'b0}}, shadow_q[rd_byte[IDX_W:1]][WEIGHT_W-1:BYTE_W]}
        : shadow_q[rd_byte[IDX_W:1]][BYTE_W-1:0];

endmodule

// File: rtl/apb_weight_completer.sv
// APB completer holding the interpolator weights; APB FSM and address decode.
// APB_CPL_WAIT_EN adds a programmable wait-state register at 0x12.
module apb_weight_completer
    import apb_cpl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 4,
    parameter int SEL_IDX    = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   i_PADDR,
    input  logic [SEL_WIDTH-1:0]    i_PSEL,
    input  logic                    i_PENABLE,
    input  logic                    i_PWRITE,
    input  logic [DATA_WIDTH-1:0]   i_PWDATA,
    input  logic [DATA_WIDTH/8-1:0] i_PSTRB,
    output logic                    o_PREADY,
    output logic [DATA_WIDTH-1:0]   o_PRDATA,
    output logic                    o_PSLVERR,
    output logic [WEIGHT_W-1:0]     o_weight0,
    output logic [WEIGHT_W-1:0]     o_weight1,
    output logic [WEIGHT_W-1:0]     o_weight2,
    output logic [WEIGHT_W-1:0]     o_weight3,
    output logic [WEIGHT_W-1:0]     o_weight4,
    output logic [WEIGHT_W-1:0]     o_weight5,
    output logic [WEIGHT_W-1:0]     o_weight6,
    output logic [WEIGHT_W-1:0]     o_weight7,
    output logic                    o_commit
);

    cpl_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [3:0]              wait_cnt;
    logic                    sel, setup, complete;
    logic                    is_weight, is_ctrl, is_status, is_wait, mapped;
    logic                    wr_fire, shadow_we, commit_req, wait_we;
    logic [DATA_WIDTH-1:0]   bank_rd, rdata;
    logic                    pending;
    logic [NUM_WEIGHTS-1:0][WEIGHT_W-1:0] committed;

    assign sel = i_PSEL[SEL_IDX];

    always_comb begin
        state_d  = state_q;
        setup    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel && !i_PENABLE) begin
                    state_d = ACCESS;
                    setup   = 1'b1;
                end
            end
            ACCESS: begin
                // Dropping PSEL mid-transfer abandons it without a response
                if (!sel) begin
                    state_d = IDLE;
                end else if (wait_cnt == 4'd0) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign is_weight = addr_q < ADDR_WIDTH'(ADDR_WLO_BASE + 2 * NUM_WEIGHTS);
    assign is_ctrl   = addr_q == ADDR_WIDTH'(ADDR_CTRL);
    assign is_status = addr_q == ADDR_WIDTH'(ADDR_STATUS);
`ifdef APB_CPL_WAIT_EN
    assign is_wait   = addr_q == ADDR_WIDTH'(ADDR_WAIT);
`else
    assign is_wait   = 1'b0;
`endif
    assign mapped    = is_weight || is_ctrl || is_status || is_wait;

    assign wr_fire    = complete && write_q && i_PSTRB[0];
    assign shadow_we  = wr_fire && is_weight;
    assign commit_req = wr_fire && is_ctrl && i_PWDATA[0];
    assign wait_we    = wr_fire && is_wait;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            o_commit <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_commit <= commit_req;
            if (setup) begin
                addr_q  <= i_PADDR;
                write_q <= i_PWRITE;
            end
        end
    end

`ifdef APB_CPL_WAIT_EN
    logic [3:0] wait_reg_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt   <= '0;
            wait_reg_q <= '0;
        end else begin
            // Loaded at setup, so a WAIT update only affects later transfers
            if (setup)
                wait_cnt <= wait_reg_q;
            else if (state_q == ACCESS && sel && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (wait_we)
                wait_reg_q <= i_PWDATA[3:0];
        end
    end
`else
    assign wait_cnt = 4'd0;
`endif

    weight_shadow_bank u_bank (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (shadow_we),
        .wr_byte   (addr_q[IDX_W:0]),
        .wr_data   (i_PWDATA),
        .commit    (commit_req),
        .rd_byte   (addr_q[IDX_W:0]),
        .rd_data   (bank_rd),
        .pending   (pending),
        .committed (committed)
    );

    always_comb begin
        rdata = '0;
        if (is_weight)
            rdata = bank_rd;
        else if (is_status)
            rdata = DATA_WIDTH'(pending);
`ifdef APB_CPL_WAIT_EN
        else if (is_wait)
            rdata = DATA_WIDTH'(wait_reg_q);
`endif
    end

    assign o_PREADY  = complete;
    assign o_PRDATA  = (complete && !write_q) ? rdata : '0;
    assign o_PSLVERR = complete && !mapped;

    assign o_weight0 = committed[0];
    assign o_weight1 = committed[1];
    assign o_weight2 = committed[2];
    assign o_weight3 = committed[3];
    assign o_weight4 = committed[4];
    assign o_weight5 = committed[5];
    assign o_weight6 = committed[6];
    assign o_weight7 = committed[7];

endmodule

// File: tb/tb_apb_weight_completer.sv
// Self-checking bench for apb_weight_completer: directed table, corner sequences, random vs model.
module tb_apb_weight_completer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [9:0] paddr = '0;
    logic [3:0] psel = '0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = '0;
    logic [0:0] pstrb = '0;
    logic       pready, pslverr, commit;
    logic [7:0] prdata;
    logic [9:0] wout [8];

    int checks = 0;
    int failures = 0;

    // Reference state, kept as plain arrays
    logic [9:0] m_shadow [8];
    logic [9:0] m_comm [8];
    bit         m_pend;
    int         m_wait;

    always #5 clk = ~clk;

    apb_weight_completer dut (
        .clk(clk), .rstn(rstn), .i_PADDR(paddr), .i_PSEL(psel), .i_PENABLE(penable),
        .i_PWRITE(pwrite), .i_PWDATA(pwdata), .i_PSTRB(pstrb),
        .o_PREADY(pready), .o_PRDATA(prdata), .o_PSLVERR(pslverr),
        .o_weight0(wout[0]), .o_weight1(wout[1]), .o_weight2(wout[2]), .o_weight3(wout[3]),
        .o_weight4(wout[4]), .o_weight5(wout[5]), .o_weight6(wout[6]), .o_weight7(wout[7]),
        .o_commit(commit)
    );

    typedef struct {
        logic [9:0] addr;
        bit         wr;
        logic [7:0] wdata;
        bit         strb;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = '0;
            m_comm[i] = '0;
        end
        m_pend = 0;
        m_wait = 0;
    endtask

    task automatic model_xfer(input logic [9:0] a, input bit w, input logic [7:0] d, input bit s,
                              output logic [7:0] er, output bit ee, output bit ec);
        int idx;
        er = '0; ee = 0; ec = 0;
        idx = int'(a) / 2;
        if (a < 16) begin
            if (w && s) begin
                if (a % 2 == 1) m_shadow[idx] = (m_shadow[idx] & 10'h0FF) | (10'(d & 8'h03) << 8);
                else            m_shadow[idx] = (m_shadow[idx] & 10'h300) | 10'(d);
                m_pend = 1;
            end else if (!w) begin
                er = (a % 2 == 1) ? 8'(m_shadow[idx] >> 8) : 8'(m_shadow[idx] % 256);
            end
        end else if (a == 10'h10) begin
            if (w && s && d[0]) begin
                for (int i = 0; i < 8; i++) m_comm[i] = m_shadow[i];
                m_pend = 0;
                ec = 1;
            end
        end else if (a == 10'h11) begin
            if (!w) er = m_pend ? 8'h01 : 8'h00;
`ifdef APB_CPL_WAIT_EN
        end else if (a == 10'h12) begin
            if (w && s) m_wait = int'(d % 16);
            else if (!w) er = 8'(m_wait);
`endif
        end else begin
            ee = 1;
        end
    endtask

    // Full APB transfer; returns just after the completing edge (cycle after PREADY)
    task automatic xfer(input logic [9:0] a, input bit w, input logic [7:0] d, input bit s,
                        output logic [7:0] rd, output bit err, output int waits);
        int n = 0;
        @(posedge clk); #1;
        psel = 4'b0001; penable = 0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1;
        while (!pready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pready) check("xfer_timeout", 0, 1);
        rd = prdata; err = pslverr; waits = n;
        @(posedge clk); #1;
        psel = '0; penable = 0;
    endtask

    task automatic run_model(input logic [9:0] a, input bit w, input logic [7:0] d, input bit s, input string tag);
        logic [7:0] er, rd;
        bit ee, ec, err;
        int waits, ew;
        ew = m_wait;
        model_xfer(a, w, d, s, er, ee, ec);
        xfer(a, w, d, s, rd, err, waits);
        check({tag, "_rdata"}, rd, er);
        check({tag, "_err"}, err, ee);
        check({tag, "_waits"}, waits, ew);
        check({tag, "_commit"}, commit, ec);
        for (int i = 0; i < 8; i++) check({tag, "_weight"}, wout[i], m_comm[i]);
    endtask

    vec_t tbl [12];

    initial begin
        logic [7:0] rd;
        bit err;
        int waits;
        logic [9:0] a;

        model_reset();
        tbl[0]  = '{10'h006, 1, 8'hAB, 1, 8'h00, 0};
        tbl[1]  = '{10'h007, 1, 8'hFE, 1, 8'h00, 0};
        tbl[2]  = '{10'h007, 0, 8'h00, 1, 8'h02, 0};
        tbl[3]  = '{10'h006, 0, 8'h00, 1, 8'hAB, 0};
        tbl[4]  = '{10'h011, 0, 8'h00, 1, 8'h01, 0};
        tbl[5]  = '{10'h3FF, 1, 8'h55, 1, 8'h00, 1};
        tbl[6]  = '{10'h020, 0, 8'h00, 1, 8'h00, 1};
        tbl[7]  = '{10'h000, 1, 8'h77, 0, 8'h00, 0};
        tbl[8]  = '{10'h000, 0, 8'h00, 1, 8'h00, 0};
        tbl[9]  = '{10'h011, 0, 8'h00, 1, 8'h01, 0};
        tbl[10] = '{10'h010, 0, 8'h00, 1, 8'h00, 0};
`ifdef APB_CPL_WAIT_EN
        tbl[11] = '{10'h012, 0, 8'h00, 1, 8'h00, 0};
`else
        tbl[11] = '{10'h012, 0, 8'h00, 1, 8'h00, 1};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pready", pready, 0);
        check("rst_commit", commit, 0);
        for (int i = 0; i < 8; i++) check("rst_weight", wout[i], 0);
        rstn = 1;
        xfer(10'h011, 0, 8'h00, 1, rd, err, waits);
        check("rst_status", rd, 8'h00);
        check("rst_status_err", err, 0);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            logic [7:0] er;
            bit ee, ec;
            model_xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].strb, er, ee, ec);
            xfer(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].strb, rd, err, waits);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            check($sformatf("tbl%0d_w3", i), wout[3], 0);
        end

        // COMMIT: weights move on the cycle after PREADY, pulse lasts one cycle
        run_model(10'h010, 1, 8'h01, 1, "commit1");
        check("commit1_w3", wout[3], 10'h2AB);
        @(posedge clk); #1;
        check("commit1_pulse_end", commit, 0);
        run_model(10'h011, 0, 8'h00, 1, "status_clr");
        run_model(10'h010, 1, 8'h01, 1, "commit_nopend");
        run_model(10'h010, 1, 8'h00, 1, "ctrl_bit0_zero");
        run_model(10'h010, 1, 8'h01, 0, "ctrl_nostrb");

`ifdef APB_CPL_WAIT_EN
        // Wait states and protocol abort
        run_model(10'h012, 1, 8'h03, 1, "wait_set");
        run_model(10'h000, 0, 8'h00, 1, "wait_read");
        @(posedge clk); #1;
        psel = 4'b0001; penable = 0; paddr = 10'h000; pwrite = 1; pwdata = 8'hC3; pstrb = 1;
        @(posedge clk); #1;
        penable = 1;
        check("abort_wait1", pready, 0);
        @(posedge clk); #1;
        check("abort_wait2", pready, 0);
        psel = '0; penable = 0;
        @(posedge clk); #1;
        check("abort_idle", pready, 0);
        run_model(10'h000, 0, 8'h00, 1, "abort_nowrite");
`endif

        // Reset in the middle of a write to 0x02
        @(posedge clk); #1;
        psel = 4'b0001; penable = 0; paddr = 10'h002; pwrite = 1; pwdata = 8'h5A; pstrb = 1;
        @(posedge clk); #1;
        penable = 1;
        rstn = 0;
        #1;
        check("midrst_pready", pready, 0);
        check("midrst_w3", wout[3], 0);
        psel = '0; penable = 0;
        @(posedge clk); #1;
        rstn = 1;
        model_reset();
        run_model(10'h002, 0, 8'h00, 1, "post_rst_read");
        run_model(10'h002, 1, 8'h3C, 1, "post_rst_write");
        run_model(10'h002, 0, 8'h00, 1, "post_rst_readback");

        // Randomised traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) a = 10'($urandom_range(0, 1023));
            else a = 10'($urandom_range(0, 19));
            if (a == 10'h012 && $urandom_range(0, 1) == 0) a = 10'h010;
            run_model(a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 5) != 0), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
